// File: rtl/rvx_wb_pkg.sv
// Shared types and defaults for the writeback arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// BUS_W normally comes from RVX_Info.v; the fallback below keeps this slice
// buildable on its own and matches the core's 32-bit datapath.
`ifndef BUS_W
`define BUS_W 32
`endif

package rvx_wb_pkg;

  localparam int WB_BUS_W      = `BUS_W;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_STARVE_MAX = 8;

  // One buffered long-latency result: destination register plus data.
  typedef struct packed {
    logic [4:0]          rd;
    logic [WB_BUS_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rv_wb_fifo.sv
// Small synchronous FIFO of writeback entries for long-latency results.
// Latency: a pushed entry becomes head on the next cycle (no bypass).
// Backpressure: push is ignored while full, pop is ignored while empty.
// Ports: clk/rst (async active-low); push/din write side; pop/head read
// side; full/empty status derived from the occupancy counter.
module rv_wb_fifo
  import rvx_wb_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed while count != 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rv_wb_arbiter.sv
// Register-file write-port arbiter: ALU results first, buffered long-latency
// results drained into idle slots. Latency: ALU 1 cycle, long unit >= 2.
// Backpressure: lu_ready = !full; alu_hold asks upstream for a bubble.
// Ports: clk/rst (async active-low); alu_* in-order results (never stalled);
// lu_* long-unit results with valid/ready; iss_long/iss_rd/iss_stall and
// pend_mask form the decode scoreboard; rf_we/rf_waddr/rf_wdata registered.
// Build option: define RVX_WB_SCOREBOARD_EN to build the pending scoreboard;
// otherwise pend_mask and iss_stall are tied low.
module rv_wb_arbiter
  import rvx_wb_pkg::*;
#(
  parameter int BUS_W      = `BUS_W,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [BUS_W-1:0] alu_data,
  input  logic             lu_valid,
  output logic             lu_ready,
  input  logic [4:0]       lu_rd,
  input  logic [BUS_W-1:0] lu_data,
  input  logic             iss_long,
  input  logic [4:0]       iss_rd,
  output logic             iss_stall,
  output logic [31:0]      pend_mask,
  output logic             alu_hold,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [BUS_W-1:0] rf_wdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_entry_t     push_ent;
  wb_entry_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_nxt;

  assign lu_ready      = !fifo_full;
  assign push          = lu_valid && lu_ready;
  // The ALU cannot be stalled, so the FIFO only drains into ALU-idle slots.
  assign pop           = !alu_valid && !fifo_empty;
  assign push_ent.rd   = lu_rd;
  assign push_ent.data = lu_data;

  rv_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_ent),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Counts cycles the head has waited; saturates so alu_hold stays up until
  // the next pop finally gets through.
  always_comb begin
    starve_nxt = starve_cnt;
    if (pop) begin
      starve_nxt = '0;
    end else if (!fifo_empty && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      starve_cnt <= '0;
      alu_hold   <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      alu_hold   <= (starve_nxt == SW'(STARVE_MAX));
      // x0 writes still consume their slot but never assert the enable.
      if (alu_valid) begin
        rf_we    <= (alu_rd != 5'd0);
        rf_waddr <= alu_rd;
        rf_wdata <= alu_data;
      end else if (pop) begin
        rf_we    <= (head.rd != 5'd0);
        rf_waddr <= head.rd;
        rf_wdata <= head.data;
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

`ifdef RVX_WB_SCOREBOARD_EN
  logic [31:0] pend_q;
  logic [31:0] pend_nxt;

  assign iss_stall = pend_q[iss_rd];
  assign pend_mask = pend_q;

  // Clear first, then set, so a same-cycle set of the popped register wins.
  always_comb begin
    pend_nxt = pend_q;
    if (pop) pend_nxt[head.rd] = 1'b0;
    if (iss_long && (iss_rd != 5'd0) && !iss_stall) pend_nxt[iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_q <= '0;
    else      pend_q <= pend_nxt;
  end
`else
  logic unused_iss;

  assign unused_iss = ^{iss_long, iss_rd};
  assign iss_stall  = 1'b0;
  assign pend_mask  = '0;
`endif

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Self-checking bench for rv_wb_arbiter: directed vector table, hand-written
// starvation and reset sequences, then randomized traffic against a
// queue-based reference model.
module tb_rv_wb_arbiter;
  import rvx_wb_pkg::*;

  localparam int W     = WB_BUS_W;
  localparam int DEPTH = WB_FIFO_DEPTH;
  localparam int SMAX  = WB_STARVE_MAX;
`ifdef RVX_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         alu_valid = 1'b0;
  logic [4:0]   alu_rd = '0;
  logic [W-1:0] alu_data = '0;
  logic         lu_valid = 1'b0;
  logic         lu_ready;
  logic [4:0]   lu_rd = '0;
  logic [W-1:0] lu_data = '0;
  logic         iss_long = 1'b0;
  logic [4:0]   iss_rd = '0;
  logic         iss_stall;
  logic [31:0]  pend_mask;
  logic         alu_hold;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [W-1:0] rf_wdata;

  always #5 clk = ~clk;

  rv_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .iss_long  (iss_long),
    .iss_rd    (iss_rd),
    .iss_stall (iss_stall),
    .pend_mask (pend_mask),
    .alu_hold  (alu_hold),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]   rd;
    logic [W-1:0] data;
  } ent_t;

  ent_t         q[$];
  bit   [31:0]  m_pend;
  int           m_starve;
  bit           m_we;
  bit           m_known;
  logic [4:0]   m_waddr;
  logic [W-1:0] m_wdata;

  task automatic model_reset();
    q.delete();
    m_pend   = '0;
    m_starve = 0;
    m_we     = 1'b0;
    m_known  = 1'b1;
    m_waddr  = '0;
    m_wdata  = '0;
  endtask

  // Called right after inputs are driven; checks combinational outputs,
  // advances the model by one clock and checks the registered outputs.
  task automatic run_cycle();
    bit   ready;
    bit   stall;
    bit   popq;
    ent_t h;
    #1;
    ready = (q.size() < DEPTH);
    stall = SB && m_pend[iss_rd];
    chk("lu_ready", 64'(lu_ready), 64'(ready));
    chk("iss_stall", 64'(iss_stall), 64'(stall));
    popq = !alu_valid && (q.size() != 0);
    if (popq) h = q[0];
    if (alu_valid) begin
      m_we = (alu_rd != 0); m_known = m_we; m_waddr = alu_rd; m_wdata = alu_data;
    end else if (popq) begin
      m_we = (h.rd != 0); m_known = m_we; m_waddr = h.rd; m_wdata = h.data;
    end else begin
      m_we = 1'b0;
    end
    if (popq) m_starve = 0;
    else if (q.size() != 0) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
    if (SB) begin
      if (popq) m_pend[h.rd] = 1'b0;
      if (iss_long && iss_rd != 0 && !stall) m_pend[iss_rd] = 1'b1;
      m_pend[0] = 1'b0;
    end
    if (popq) void'(q.pop_front());
    if (lu_valid && ready) q.push_back('{lu_rd, lu_data});
    @(posedge clk);
    #1;
    chk("rf_we", 64'(rf_we), 64'(m_we));
    if (m_known) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
      chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    end
    chk("pend_mask", 64'(pend_mask), 64'(m_pend));
    chk("alu_hold", 64'(alu_hold), 64'(m_starve == SMAX));
  endtask

  task automatic drive(input bit av, input int ard, input int ad, input bit lv,
                       input int lrd, input int ld, input bit il, input int ir);
    alu_valid = av; alu_rd = 5'(ard); alu_data = W'(ad);
    lu_valid  = lv; lu_rd  = 5'(lrd); lu_data  = W'(ld);
    iss_long  = il; iss_rd = 5'(ir);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit av; int ard; int ad;
    bit lv; int lrd; int ld;
    bit il; int ir;
    bit e_stall; bit e_we; int e_wa; int e_wd; bit e_known; bit e_rdy; int e_pend;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl[NV];

  function automatic vec_t mk(bit av, int ard, int ad, bit lv, int lrd, int ld,
                              bit il, int ir, bit es, bit ew, int ewa, int ewd,
                              bit ek, bit erdy, int ep);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.il = il; v.ir = ir; v.e_stall = es; v.e_we = ew; v.e_wa = ewa;
    v.e_wd = ewd; v.e_known = ek; v.e_rdy = erdy; v.e_pend = ep;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    //            alu          lu              iss    stall we wa  wd     known rdy pend
    tbl[0]  = mk(0, 0, 0,      0, 0, 0,        0, 0,  0, 0, 0, 0,      1, 1, 0);
    tbl[1]  = mk(1, 5, 'h1234, 0, 0, 0,        0, 0,  0, 1, 5, 'h1234, 1, 1, 0);
    tbl[2]  = mk(0, 0, 0,      0, 0, 0,        1, 7,  0, 0, 5, 'h1234, 1, 1, 'h80);
    tbl[3]  = mk(0, 0, 0,      1, 7, 'hDEAD,   0, 0,  0, 0, 5, 'h1234, 1, 1, 'h80);
    tbl[4]  = mk(0, 0, 0,      0, 0, 0,        0, 0,  0, 1, 7, 'hDEAD, 1, 1, 0);
    tbl[5]  = mk(0, 0, 0,      0, 0, 0,        1, 3,  0, 0, 7, 'hDEAD, 1, 1, 'h08);
    tbl[6]  = mk(0, 0, 0,      0, 0, 0,        1, 3,  1, 0, 7, 'hDEAD, 1, 1, 'h08);
    tbl[7]  = mk(0, 0, 0,      0, 0, 0,        1, 0,  0, 0, 7, 'hDEAD, 1, 1, 'h08);
    tbl[8]  = mk(0, 0, 0,      1, 0, 'h55,     0, 0,  0, 0, 7, 'hDEAD, 1, 1, 'h08);
    tbl[9]  = mk(1, 9, 'h99,   0, 0, 0,        0, 0,  0, 1, 9, 'h99,   1, 1, 'h08);
    tbl[10] = mk(0, 0, 0,      0, 0, 0,        0, 0,  0, 0, 0, 0,      0, 1, 'h08);

    // Asynchronous reset assertion with no clock edge involved.
    model_reset();
    #2 rst = 1'b0;
    #1;
    chk("reset_rf_we", 64'(rf_we), 64'(0));
    chk("reset_rf_waddr", 64'(rf_waddr), 64'(0));
    chk("reset_rf_wdata", 64'(rf_wdata), 64'(0));
    chk("reset_lu_ready", 64'(lu_ready), 64'(1));
    chk("reset_pend_mask", 64'(pend_mask), 64'(0));
    chk("reset_alu_hold", 64'(alu_hold), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      run_cycle();
    end

    // Directed vectors.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ld,
            tbl[i].il, tbl[i].ir);
      #1;
      chk($sformatf("v%0d_stall", i), 64'(iss_stall), 64'(SB & tbl[i].e_stall));
      run_cycle();
      chk($sformatf("v%0d_we", i), 64'(rf_we), 64'(tbl[i].e_we));
      if (tbl[i].e_known) begin
        chk($sformatf("v%0d_waddr", i), 64'(rf_waddr), 64'(5'(tbl[i].e_wa)));
        chk($sformatf("v%0d_wdata", i), 64'(rf_wdata), 64'(W'(tbl[i].e_wd)));
      end
      chk($sformatf("v%0d_ready", i), 64'(lu_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("v%0d_pend", i), 64'(pend_mask), SB ? 64'(tbl[i].e_pend) : 64'(0));
    end

    // Fill the FIFO under continuous ALU traffic, then starve it.
    drive(1, 1, 'h1, 1, 10, 'hA0A0, 0, 0);
    run_cycle();
    drive(1, 2, 'h2, 1, 11, 'hB0B0, 0, 0);
    run_cycle();
    chk("full_lu_ready", 64'(lu_ready), 64'(0));
    for (int i = 0; i < 6; i++) begin
      drive(1, 3, i, 0, 0, 0, 0, 0);
      run_cycle();
    end
    chk("starve7_hold", 64'(alu_hold), 64'(0));
    drive(1, 4, 'h4, 0, 0, 0, 0, 0);
    run_cycle();
    chk("starve8_hold", 64'(alu_hold), 64'(1));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();
    chk("drain1_we", 64'(rf_we), 64'(1));
    chk("drain1_waddr", 64'(rf_waddr), 64'(10));
    chk("drain1_wdata", 64'(rf_wdata), 64'(W'('hA0A0)));
    chk("drain1_hold", 64'(alu_hold), 64'(0));
    run_cycle();
    chk("drain2_waddr", 64'(rf_waddr), 64'(11));
    chk("drain2_wdata", 64'(rf_wdata), 64'(W'('hB0B0)));
    chk("drain2_ready", 64'(lu_ready), 64'(1));

    // Reset with two entries buffered and a pending bit set.
    drive(1, 20, 'h20, 0, 0, 0, 1, 12);
    run_cycle();
    drive(1, 21, 'h21, 1, 13, 'hC, 0, 0);
    run_cycle();
    drive(1, 22, 'h22, 1, 14, 'hD, 0, 0);
    run_cycle();
    chk("prerst_ready", 64'(lu_ready), 64'(0));
    #2 rst = 1'b0;
    #1;
    chk("midrst_rf_we", 64'(rf_we), 64'(0));
    chk("midrst_waddr", 64'(rf_waddr), 64'(0));
    chk("midrst_ready", 64'(lu_ready), 64'(1));
    chk("midrst_pend", 64'(pend_mask), 64'(0));
    chk("midrst_hold", 64'(alu_hold), 64'(0));
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_rf_we", 64'(rf_we), 64'(0));
    for (int i = 0; i < 3; i++) run_cycle();

    // Randomized traffic; the long unit keeps an unaccepted offer stable and
    // upstream honours alu_hold immediately.
    for (int i = 0; i < 400; i++) begin
      int pct;
      pct = (i < 200) ? 80 : 35;
      if (!(lu_valid && (q.size() == DEPTH))) begin
        lu_valid = ($urandom_range(0, 99) < 50);
        lu_rd    = 5'($urandom_range(0, 7));
        lu_data  = W'($urandom);
      end
      alu_valid = !alu_hold && ($urandom_range(0, 99) < pct);
      alu_rd    = 5'($urandom_range(0, 31));
      alu_data  = W'($urandom);
      iss_long  = ($urandom_range(0, 99) < 30);
      iss_rd    = 5'($urandom_range(0, 7));
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
